// File: rtl/ysyx_22050133_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_22050133_ifu_pkg;

    // Core-wide widths and the architectural reset vector.
    localparam int unsigned       IFU_XLEN     = 64;
    localparam int unsigned       IFU_ILEN     = 32;
    localparam logic [63:0]       IFU_RESET_PC = 64'h8000_0000;
    localparam logic [31:0]       IFU_INST_NOP = 32'h0000_0013;

    // One fetch buffer entry: the PC and the word fetched from it.
    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [IFU_ILEN-1:0] inst;
    } fetch_entry_t;

    // FETCH accepts responses; DRAIN discards wrong-path responses still in flight.
    typedef enum logic {
        StFetch,
        StDrain
    } fetch_state_e;

    // Next sequential instruction address; wraps silently at the top of memory.
    function automatic logic [IFU_XLEN-1:0] pc_next(input logic [IFU_XLEN-1:0] pc);
        return pc + 64'd4;
    endfunction

    // Force a target onto a word boundary.
    function automatic logic [IFU_XLEN-1:0] word_align(input logic [IFU_XLEN-1:0] addr);
        return addr & ~64'h3;
    endfunction

endpackage

// File: rtl/ysyx_22050133_ifu_fifo.sv
// Synchronous fetch buffer holding {pc, inst} entries. Flush wins over push.
module ysyx_22050133_ifu_fifo
    import ysyx_22050133_ifu_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(Depth):0]       count,
    output logic                         empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push;
    logic            do_pop;
    logic            full;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Pointer and occupancy next-state; Depth is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; reset to NOPs so the idle head is a harmless instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '{pc: '0, inst: IFU_INST_NOP};
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

`ifndef SYNTHESIS
    // The credit limit upstream must keep the buffer from ever overflowing.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(do_push && full))
                else $error("ifu_fifo: push while full");
        end
    end
`endif

endmodule

// File: rtl/ysyx_22050133_ifu.sv
// RV64 instruction fetch: owns the fetch PC, issues in-order word requests, buffers
// responses and hands {pc, inst} to decode. EX redirects flush and drain wrong-path fetches.
module ysyx_22050133_ifu
    import ysyx_22050133_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = IFU_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [63:0]     fetch_pc_q, fetch_pc_d;
    logic [63:0]     resp_pc_q, resp_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

    fetch_state_e    state;
    logic [CntW-1:0] fifo_count;
    logic            fifo_empty;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;
    logic            fifo_push;
    logic            fifo_pop;
    logic [CntW:0]   in_use;
    logic            credit_ok;
    logic            req_fire;
    logic [63:0]     redirect_target;

    // Drain state is purely a function of how many wrong-path words are still due.
    assign state = (drop_cnt_q != '0) ? StDrain : StFetch;

    // Credit covers both in-flight requests and buffered words, using start-of-cycle counts.
    assign in_use    = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign credit_ok = (in_use < (CntW + 1)'(FIFO_DEPTH));

    assign redirect_target = word_align(redirect_pc);

    // Handshake outputs; a redirect suppresses both issue and hand-off in its cycle.
    always_comb begin
        imem_req_valid = !rst && !redirect_valid && credit_ok;
        imem_req_addr  = fetch_pc_q;
        out_valid      = !fifo_empty && !redirect_valid;
        out_pc         = fifo_head.pc;
        out_inst       = fifo_head.inst;
    end

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign fifo_pop  = out_valid && out_ready;
    assign fifo_push = imem_resp_valid && !redirect_valid && (state == StFetch);

    assign push_entry = '{pc: resp_pc_q, inst: imem_resp_data};

    // Next-state for the PCs and the outstanding/drop counters; redirect has priority.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d    = redirect_target;
            resp_pc_d     = redirect_target;
            // Everything still in flight belongs to the old path.
            outstanding_d = outstanding_q - CntW'(imem_resp_valid);
            drop_cnt_d    = outstanding_q - CntW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = pc_next(fetch_pc_q);
            end
            outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_resp_valid);
            if (imem_resp_valid) begin
                if (state == StDrain) begin
                    drop_cnt_d = drop_cnt_q - CntW'(1);
                end else begin
                    resp_pc_d = pc_next(resp_pc_q);
                end
            end
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    ysyx_22050133_ifu_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

`ifndef SYNTHESIS
    // Memory must never answer a request that was not issued.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_resp_valid && outstanding_q == '0))
                else $error("ifu: response with no outstanding request");
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22050133_ifu.sv
// Directed bench for the fetch unit: a per-cycle vector table plus hand-written sequences
// driven by a fixed-latency in-order memory model.
module tb_ysyx_22050133_ifu;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    // Response source: table-driven or memory model.
    logic        mem_en = 1'b0;
    logic        tbl_resp_valid = 1'b0;
    logic [31:0] tbl_resp_data = '0;
    logic        mdl_valid = 1'b0;
    logic [31:0] mdl_data = '0;

    assign imem_resp_valid = mem_en ? mdl_valid : tbl_resp_valid;
    assign imem_resp_data  = mem_en ? mdl_data : tbl_resp_data;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_22050133_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst)
    );

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // In-order memory with fixed latency, reset by the same rst.
    logic [63:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;
    int          mem_lat = 1;
    int          fire_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
            fire_cnt = 0;
        end else if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + mem_lat);
            fire_cnt++;
        end
        cyc++;
        #1;
        if (mq_due.size() > 0 && mq_due[0] == cyc) begin
            mdl_valid = 1'b1;
            mdl_data  = inst_of(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            mdl_valid = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds rst for two cycles; returns just after the edge that starts cycle 0.
    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        tbl_resp_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [63:0] got_pc[8];
    logic [31:0] got_inst[8];
    int          got_n;

    // Records up to n accepted outputs within a cycle budget.
    task automatic collect(input int n, input int budget);
        got_n = 0;
        for (int c = 0; c < budget && got_n < n; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got_pc[got_n]   = out_pc;
                got_inst[got_n] = out_inst;
                got_n++;
            end
            tick();
        end
    endtask

    typedef struct packed {
        logic        req_ready;
        logic        resp_valid;
        logic [31:0] resp_data;
        logic        redir;
        logic [63:0] redir_pc;
        logic        o_ready;
        logic        e_req_valid;
        logic [63:0] e_req_addr;
        logic        e_out_valid;
        logic [63:0] e_out_pc;
        logic [31:0] e_out_inst;
    } vec_t;

    function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] rd,
                                input logic rdv, input logic [63:0] rdp, input logic ordy,
                                input logic eqv, input logic [63:0] eqa, input logic eov,
                                input logic [63:0] eop, input logic [31:0] eoi);
        return '{rr, rv, rd, rdv, rdp, ordy, eqv, eqa, eov, eop, eoi};
    endfunction

    localparam int NVec = 19;
    vec_t vecs[NVec];

    initial begin
        // Single-cycle memory: a fire in cycle k answers in cycle k+1.
        //              rdy rv data          rd  rdpc          ord  eqv eaddr          eov epc            einst
        vecs[0]  = mk(1, 0, 32'h0,         0, 64'h0,         1,   1, 64'h8000_0000, 0, 64'h0,         32'h0);
        vecs[1]  = mk(1, 1, 32'hC0DE_0000, 0, 64'h0,         1,   1, 64'h8000_0004, 0, 64'h0,         32'h0);
        vecs[2]  = mk(1, 1, 32'hC0DE_0004, 0, 64'h0,         1,   0, 64'h8000_0008, 1, 64'h8000_0000, 32'hC0DE_0000);
        vecs[3]  = mk(1, 0, 32'h0,         0, 64'h0,         1,   1, 64'h8000_0008, 1, 64'h8000_0004, 32'hC0DE_0004);
        vecs[4]  = mk(1, 1, 32'hC0DE_0008, 0, 64'h0,         1,   1, 64'h8000_000C, 0, 64'h0,         32'h0);
        // Redirect alongside a response and a would-be pop.
        vecs[5]  = mk(1, 1, 32'hC0DE_000C, 1, 64'h8000_0100, 1,   0, 64'h8000_0010, 0, 64'h0,         32'h0);
        vecs[6]  = mk(1, 0, 32'h0,         0, 64'h0,         1,   1, 64'h8000_0100, 0, 64'h0,         32'h0);
        vecs[7]  = mk(1, 1, 32'hC0DE_0100, 0, 64'h0,         1,   1, 64'h8000_0104, 0, 64'h0,         32'h0);
        vecs[8]  = mk(1, 1, 32'hC0DE_0104, 0, 64'h0,         1,   0, 64'h8000_0108, 1, 64'h8000_0100, 32'hC0DE_0100);
        // Misaligned target, masking a pop and an issue that would otherwise happen.
        vecs[9]  = mk(1, 0, 32'h0,         1, 64'h8000_0203, 1,   0, 64'h8000_0108, 0, 64'h0,         32'h0);
        vecs[10] = mk(1, 0, 32'h0,         0, 64'h0,         1,   1, 64'h8000_0200, 0, 64'h0,         32'h0);
        // Back-to-back redirects A then B.
        vecs[11] = mk(1, 1, 32'hC0DE_0200, 1, 64'h8000_0300, 1,   0, 64'h8000_0204, 0, 64'h0,         32'h0);
        vecs[12] = mk(1, 0, 32'h0,         1, 64'h8000_0400, 1,   0, 64'h8000_0300, 0, 64'h0,         32'h0);
        vecs[13] = mk(1, 0, 32'h0,         0, 64'h0,         1,   1, 64'h8000_0400, 0, 64'h0,         32'h0);
        vecs[14] = mk(1, 1, 32'hC0DE_0400, 0, 64'h0,         1,   1, 64'h8000_0404, 0, 64'h0,         32'h0);
        vecs[15] = mk(1, 1, 32'hC0DE_0404, 0, 64'h0,         1,   0, 64'h8000_0408, 1, 64'h8000_0400, 32'hC0DE_0400);
        vecs[16] = mk(1, 0, 32'h0,         0, 64'h0,         1,   1, 64'h8000_0408, 1, 64'h8000_0404, 32'hC0DE_0404);
        // Memory not ready: address must hold until it fires.
        vecs[17] = mk(0, 1, 32'hC0DE_0408, 0, 64'h0,         1,   1, 64'h8000_040C, 0, 64'h0,         32'h0);
        vecs[18] = mk(1, 0, 32'h0,         0, 64'h0,         1,   1, 64'h8000_040C, 1, 64'h8000_0408, 32'hC0DE_0408);

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);

        // Vector table.
        do_reset();
        mem_en = 1'b0;
        for (int i = 0; i < NVec; i++) begin
            imem_req_ready = vecs[i].req_ready;
            tbl_resp_valid = vecs[i].resp_valid;
            tbl_resp_data  = vecs[i].resp_data;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].redir_pc;
            out_ready      = vecs[i].o_ready;
            @(negedge clk);
            chk($sformatf("v%0d_req_valid", i), 64'(imem_req_valid), 64'(vecs[i].e_req_valid));
            chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_req_addr);
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_out_valid));
            if (vecs[i].e_out_valid) begin
                chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].e_out_pc);
                chk($sformatf("v%0d_out_inst", i), 64'(out_inst), 64'(vecs[i].e_out_inst));
            end
            tick();
        end
        tbl_resp_valid = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;

        // Stall: out_ready low for 10 cycles, buffer fills after two fires.
        mem_en  = 1'b1;
        mem_lat = 1;
        do_reset();
        out_ready = 1'b0;
        begin
            int stall_bad;
            stall_bad = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (c >= 2 && !(out_valid && out_pc == RST_PC && out_inst == inst_of(RST_PC)))
                    stall_bad++;
                if (c == 9) chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
                tick();
            end
            chk("stall_fires", 64'(fire_cnt), 64'd2);
            chk("stall_head_bad", 64'(stall_bad), 64'd0);
        end
        out_ready = 1'b1;
        collect(6, 40);
        chk("drain_count", 64'(got_n), 64'd6);
        for (int i = 0; i < got_n; i++) begin
            chk($sformatf("drain%0d_pc", i), got_pc[i], RST_PC + 64'(4 * i));
            chk($sformatf("drain%0d_inst", i), 64'(got_inst[i]), 64'(inst_of(RST_PC + 64'(4 * i))));
        end

        // Latency 3, two in flight, then redirect: both stale words must vanish.
        mem_lat = 3;
        do_reset();
        out_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        @(negedge clk);
        chk("lat3_redir_req_valid", 64'(imem_req_valid), 64'd0);
        chk("lat3_redir_out_valid", 64'(out_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        collect(2, 40);
        chk("lat3_count", 64'(got_n), 64'd2);
        chk("lat3_first_pc", got_pc[0], 64'h8000_0100);
        chk("lat3_first_inst", 64'(got_inst[0]), 64'(inst_of(64'h8000_0100)));
        chk("lat3_second_pc", got_pc[1], 64'h8000_0104);

        // Reset mid-stream with a full buffer.
        mem_lat = 1;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_r0_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("midrst_r1_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_r1_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_req_valid", 64'(imem_req_valid), 64'd1);
        chk("midrst_req_addr", imem_req_addr, RST_PC);
        tick();
        collect(1, 20);
        chk("midrst_count", 64'(got_n), 64'd1);
        chk("midrst_first_pc", got_pc[0], RST_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
